// File: rtl/font_rom_arbiter.sv
// -----------------------------------------------------------------------------
// font_rom_arbiter
//
// Lets the two text-overlay stages of the VGA pipeline share one synchronous
// font ROM. Requests are granted round-robin with a combinational grant. The
// winner's address is registered onto rom_addr. A {valid, id} tag travels
// alongside the ROM read, so that each glyph row is routed back to the overlay
// that asked for it, ROM_LAT+2 cycles after the grant.
//
// Parameters
//   ADDR_W  : ROM address width ({char_code, char_line})
//   DATA_W  : glyph row width
//   ROM_LAT : ROM read latency, rom_addr -> rom_data, legal range 1..4
//
// Ports
//   clk              pixel clock
//   rst              asynchronous reset, active low
//   req0/addr0       overlay 0 request; address held until gnt0
//   gnt0             one-cycle accept pulse to overlay 0
//   rvalid0/rdata0   glyph row return to overlay 0
//   req1 .. rdata1   the same set for overlay 1
//   rom_addr         registered address to the shared ROM
//   rom_data         ROM output, valid ROM_LAT cycles after rom_addr
// -----------------------------------------------------------------------------
module font_rom_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  // The final tag stage lines up with the cycle in which rom_data is valid.
  localparam int DEPTH = ROM_LAT + 1;

  logic              last_winner_q, last_winner_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DEPTH-1:0]  tag_vld_q, tag_vld_d;
  logic [DEPTH-1:0]  tag_id_q, tag_id_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic gnt0_c, gnt1_c, any_gnt, winner;
  logic ret_vld, ret_id;

  // Round-robin grant. A lone requester always wins. Under contention the
  // requester that did not win last time wins now. Grants are masked while
  // reset is held.
  always_comb begin
    gnt0_c  = rst & req0 & (~req1 | last_winner_q);
    gnt1_c  = rst & req1 & (~req0 | ~last_winner_q);
    any_gnt = gnt0_c | gnt1_c;
    winner  = gnt1_c;
  end

  always_comb begin
    last_winner_d = last_winner_q;
    rom_addr_d    = rom_addr_q;
    if (gnt0_c) begin
      last_winner_d = 1'b0;
      rom_addr_d    = addr0;
    end else if (gnt1_c) begin
      last_winner_d = 1'b1;
      rom_addr_d    = addr1;
    end

    // The tag pipe shifts unconditionally. The id bit of an empty slot is
    // don't-care, so the winner bit is loaded either way.
    tag_vld_d = {tag_vld_q[DEPTH-2:0], any_gnt};
    tag_id_d  = {tag_id_q[DEPTH-2:0], winner};

    ret_vld = tag_vld_q[DEPTH-1];
    ret_id  = tag_id_q[DEPTH-1];

    rvalid0_d = ret_vld & ~ret_id;
    rvalid1_d = ret_vld & ret_id;
    rdata0_d  = rvalid0_d ? rom_data : rdata0_q;
    rdata1_d  = rvalid1_d ? rom_data : rdata1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_winner_q <= 1'b1;
      rom_addr_q    <= '0;
      tag_vld_q     <= '0;
      tag_id_q      <= '0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      last_winner_q <= last_winner_d;
      rom_addr_q    <= rom_addr_d;
      tag_vld_q     <= tag_vld_d;
      tag_id_q      <= tag_id_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
    end
  end

  assign gnt0     = gnt0_c;
  assign gnt1     = gnt1_c;
  assign rom_addr = rom_addr_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_font_rom_arbiter
//
// Drives two arbiter instances:
//   dut_a uses ROM_LAT=1.
//   dut_b uses ROM_LAT=3.
// Each instance has a behavioural ROM whose contents are a fixed function of
// the address. Every observed grant pushes {id, expected row, expected cycle}
// into a scoreboard queue. Every rvalid pops an entry and compares it against
// the row that came back. The scenario tasks check grants and outputs inline.
// -----------------------------------------------------------------------------
module tb_font_rom_arbiter;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   resp_a = 0;
  int   resp_b = 0;
  logic model_lw;

  // Signals for dut_a (ROM_LAT=1).
  logic        req0_a = 1'b0, req1_a = 1'b0;
  logic [10:0] addr0_a = '0, addr1_a = '0;
  logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a;
  logic [7:0]  rdata0_a, rdata1_a, rom_data_a;
  logic [10:0] rom_addr_a;

  // Signals for dut_b (ROM_LAT=3).
  logic        req0_b = 1'b0, req1_b = 1'b0;
  logic [10:0] addr0_b = '0, addr1_b = '0;
  logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b;
  logic [7:0]  rdata0_b, rdata1_b;
  logic [10:0] rom_addr_b;
  logic [7:0]  rom_b [3];

  exp_t sb_a[$];
  exp_t sb_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Font ROM contents: 0x123 holds 0xA5.
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], 5'b0} ^ 8'hA6;
  endfunction

  always @(posedge clk) rom_data_a <= rom_fn(rom_addr_a);
  always @(posedge clk) begin
    rom_b[0] <= rom_fn(rom_addr_b);
    rom_b[1] <= rom_b[0];
    rom_b[2] <= rom_b[1];
  end

  font_rom_arbiter #(.ADDR_W(11), .DATA_W(8), .ROM_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0_a), .addr0(addr0_a), .gnt0(gnt0_a), .rvalid0(rvalid0_a), .rdata0(rdata0_a),
    .req1(req1_a), .addr1(addr1_a), .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rdata1(rdata1_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a)
  );

  font_rom_arbiter #(.ADDR_W(11), .DATA_W(8), .ROM_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0_b), .addr0(addr0_b), .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
    .req1(req1_b), .addr1(addr1_b), .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
    .rom_addr(rom_addr_b), .rom_data(rom_b[2])
  );

  // Scoreboard for dut_a: expected return cycle is grant cycle + 3.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb_a.delete();
      end else begin
        if (gnt0_a && gnt1_a) begin
          checks++; errors++;
          $display("FAIL onehot_a gnt0=%b gnt1=%b required not both", gnt0_a, gnt1_a);
        end
        if (rvalid0_a || rvalid1_a) begin
          checks++;
          if (rvalid0_a && rvalid1_a) begin
            errors++;
            $display("FAIL rvalid_both_a at cycle %0d", cyc);
          end else if (sb_a.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rvalid_a id=%0d at cycle %0d required none", rvalid1_a, cyc);
          end else begin
            e = sb_a.pop_front();
            resp_a++;
            $display("resp a id=%0d data=%h cyc=%0d", rvalid1_a, rvalid1_a ? rdata1_a : rdata0_a, cyc);
            if (rvalid1_a !== e.id || (rvalid1_a ? rdata1_a : rdata0_a) !== e.data || cyc !== e.cyc)
              begin
                errors++;
                $display("FAIL resp_a got id=%0d data=%h cyc=%0d required id=%0d data=%h cyc=%0d",
                         rvalid1_a, rvalid1_a ? rdata1_a : rdata0_a, cyc, e.id, e.data, e.cyc);
              end
          end
        end
        if (gnt0_a) begin
          e.id = 1'b0; e.data = rom_fn(addr0_a); e.cyc = cyc + 3; sb_a.push_back(e);
        end
        if (gnt1_a) begin
          e.id = 1'b1; e.data = rom_fn(addr1_a); e.cyc = cyc + 3; sb_a.push_back(e);
        end
      end
    end
  end

  // Scoreboard for dut_b: expected return cycle is grant cycle + 5.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb_b.delete();
      end else begin
        if (rvalid0_b || rvalid1_b) begin
          checks++;
          if ((rvalid0_b && rvalid1_b) || sb_b.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rvalid_b r0=%b r1=%b at cycle %0d", rvalid0_b, rvalid1_b, cyc);
          end else begin
            e = sb_b.pop_front();
            resp_b++;
            $display("resp b id=%0d data=%h cyc=%0d", rvalid1_b, rvalid1_b ? rdata1_b : rdata0_b, cyc);
            if (rvalid1_b !== e.id || (rvalid1_b ? rdata1_b : rdata0_b) !== e.data || cyc !== e.cyc)
              begin
                errors++;
                $display("FAIL resp_b got id=%0d data=%h cyc=%0d required id=%0d data=%h cyc=%0d",
                         rvalid1_b, rvalid1_b ? rdata1_b : rdata0_b, cyc, e.id, e.data, e.cyc);
              end
          end
        end
        if (gnt0_b) begin
          e.id = 1'b0; e.data = rom_fn(addr0_b); e.cyc = cyc + 5; sb_b.push_back(e);
        end
        if (gnt1_b) begin
          e.id = 1'b1; e.data = rom_fn(addr1_b); e.cyc = cyc + 5; sb_b.push_back(e);
        end
      end
    end
  end

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    req0_a = 1'b1; req1_a = 1'b1; addr0_a = 11'h011; addr1_a = 11'h022;
    #2 rst = 1'b0;
    tick(); tick(); smp();
    checks++;
    if ({gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, gnt0_b, gnt1_b, rvalid0_b, rvalid1_b} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 00000000",
               {gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, gnt0_b, gnt1_b, rvalid0_b, rvalid1_b});
    end
    checks++;
    if (rom_addr_a !== 11'h000 || rom_addr_b !== 11'h000 || rdata0_a !== 8'h00 || rdata1_a !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got rom_addr=%h rdata0=%h rdata1=%h required 000/00/00",
               rom_addr_a, rdata0_a, rdata1_a);
    end
  endtask

  task automatic test_contention_after_reset();
    int r0;
    r0 = resp_a;
    tick(); rst = 1'b1; smp();
    checks++;
    if ({gnt0_a, gnt1_a} !== 2'b10) begin
      errors++; $display("FAIL first_contention got %b required 10", {gnt0_a, gnt1_a});
    end
    tick(); req0_a = 1'b0; smp();
    checks++;
    if ({gnt0_a, gnt1_a} !== 2'b01) begin
      errors++; $display("FAIL second_grant got %b required 01", {gnt0_a, gnt1_a});
    end
    tick(); req1_a = 1'b0;
    repeat (5) tick();
    checks++;
    if (resp_a - r0 !== 2) begin
      errors++; $display("FAIL contention_resp_count got %0d required 2", resp_a - r0);
    end
  endtask

  task automatic test_single();
    tick(); req0_a = 1'b1; addr0_a = 11'h123; smp();
    checks++;
    if ({gnt0_a, gnt1_a} !== 2'b10) begin
      errors++; $display("FAIL single_gnt got %b required 10", {gnt0_a, gnt1_a});
    end
    tick(); req0_a = 1'b0; smp();
    checks++;
    if (rom_addr_a !== 11'h123) begin
      errors++; $display("FAIL single_rom_addr got %h required 123", rom_addr_a);
    end
    tick(); smp();
    checks++;
    if (rvalid0_a !== 1'b0) begin
      errors++; $display("FAIL single_early got rvalid0=%b required 0", rvalid0_a);
    end
    tick(); smp();
    checks++;
    if (rvalid0_a !== 1'b1 || rdata0_a !== 8'hA5 || rvalid1_a !== 1'b0) begin
      errors++;
      $display("FAIL single_resp got rvalid0=%b rdata0=%h rvalid1=%b required 1/a5/0",
               rvalid0_a, rdata0_a, rvalid1_a);
    end
    repeat (3) tick();
    model_lw = 1'b0;
  endtask

  task automatic test_sustained();
    int g0, g1, r0;
    logic exp_w, saw0, saw1;
    g0 = 0; g1 = 0; r0 = resp_a;
    tick(); req0_a = 1'b1; req1_a = 1'b1; addr0_a = 11'h200; addr1_a = 11'h300;
    for (int i = 0; i < 20; i++) begin
      smp();
      exp_w = ~model_lw;
      saw0 = gnt0_a; saw1 = gnt1_a;
      checks++;
      if ({saw0, saw1} !== (exp_w ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL sustained_gnt[%0d] got %b required %b", i, {saw0, saw1}, exp_w ? 2'b01 : 2'b10);
      end
      model_lw = exp_w;
      if (saw0) g0++;
      if (saw1) g1++;
      tick();
      if (saw0) addr0_a = addr0_a + 11'd1;
      if (saw1) addr1_a = addr1_a + 11'd1;
    end
    req0_a = 1'b0; req1_a = 1'b0;
    checks++;
    if (g0 !== 10 || g1 !== 10) begin
      errors++; $display("FAIL sustained_split got %0d/%0d required 10/10", g0, g1);
    end
    repeat (6) tick();
    checks++;
    if (resp_a - r0 !== 20) begin
      errors++; $display("FAIL sustained_resp_count got %0d required 20", resp_a - r0);
    end
  endtask

  task automatic test_reset_midflight();
    int r0;
    tick(); req0_a = 1'b1; addr0_a = 11'h055; smp();
    checks++;
    if ({gnt0_a, gnt1_a} !== 2'b10) begin
      errors++; $display("FAIL midflight_gnt got %b required 10", {gnt0_a, gnt1_a});
    end
    tick(); req1_a = 1'b1; addr1_a = 11'h066; rst = 1'b0; smp();
    checks++;
    if ({gnt0_a, gnt1_a, rvalid0_a, rvalid1_a} !== 4'b0000 || rom_addr_a !== 11'h000 ||
        rdata0_a !== 8'h00 || rdata1_a !== 8'h00) begin
      errors++;
      $display("FAIL midflight_reset got ctl=%b rom_addr=%h rdata0=%h rdata1=%h required 0000/000/00/00",
               {gnt0_a, gnt1_a, rvalid0_a, rvalid1_a}, rom_addr_a, rdata0_a, rdata1_a);
    end
    r0 = resp_a;
    tick(); rst = 1'b1; smp();
    checks++;
    if ({gnt0_a, gnt1_a} !== 2'b10) begin
      errors++; $display("FAIL post_reset_winner got %b required 10", {gnt0_a, gnt1_a});
    end
    tick(); req0_a = 1'b0; smp();
    checks++;
    if ({gnt0_a, gnt1_a} !== 2'b01) begin
      errors++; $display("FAIL post_reset_second got %b required 01", {gnt0_a, gnt1_a});
    end
    tick(); req1_a = 1'b0;
    repeat (6) tick();
    checks++;
    if (resp_a - r0 !== 2) begin
      errors++; $display("FAIL midflight_resp_count got %0d required 2", resp_a - r0);
    end
  endtask

  task automatic test_withdraw();
    int r0;
    r0 = resp_a;
    tick(); req0_a = 1'b1; req1_a = 1'b1; addr0_a = 11'h0AA; addr1_a = 11'h0BB; smp();
    checks++;
    if ({gnt0_a, gnt1_a} !== 2'b10) begin
      errors++; $display("FAIL withdraw_gnt got %b required 10", {gnt0_a, gnt1_a});
    end
    tick(); req0_a = 1'b0; req1_a = 1'b0; smp();
    checks++;
    if ({gnt0_a, gnt1_a} !== 2'b00) begin
      errors++; $display("FAIL withdraw_idle got %b required 00", {gnt0_a, gnt1_a});
    end
    tick(); req0_a = 1'b1; req1_a = 1'b1; addr0_a = 11'h0CC; addr1_a = 11'h0DD; smp();
    checks++;
    if ({gnt0_a, gnt1_a} !== 2'b01) begin
      errors++; $display("FAIL withdraw_lw got %b required 01", {gnt0_a, gnt1_a});
    end
    tick(); req1_a = 1'b0; smp();
    checks++;
    if ({gnt0_a, gnt1_a} !== 2'b10) begin
      errors++; $display("FAIL withdraw_follow got %b required 10", {gnt0_a, gnt1_a});
    end
    tick(); req0_a = 1'b0;
    repeat (5) tick();
    checks++;
    if (resp_a - r0 !== 3) begin
      errors++; $display("FAIL withdraw_resp_count got %0d required 3", resp_a - r0);
    end
  endtask

  task automatic test_latency();
    int r0;
    r0 = resp_b;
    for (int i = 0; i < 4; i++) begin
      tick();
      req0_b = (i % 2 == 0); req1_b = (i % 2 == 1);
      addr0_b = 11'h400 + 11'(i * 17); addr1_b = 11'h500 + 11'(i * 17);
      smp();
      checks++;
      if ({gnt0_b, gnt1_b} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL lat3_gnt[%0d] got %b", i, {gnt0_b, gnt1_b});
      end
    end
    tick(); req0_b = 1'b0; req1_b = 1'b0;
    repeat (8) tick();
    checks++;
    if (resp_b - r0 !== 4) begin
      errors++; $display("FAIL lat3_resp_count got %0d required 4", resp_b - r0);
    end
  endtask

  initial begin
    model_lw = 1'b1;
    test_reset();
    test_contention_after_reset();
    test_single();
    test_sustained();
    test_reset_midflight();
    test_withdraw();
    test_latency();
    checks++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d outstanding required 0/0", sb_a.size(), sb_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
